// File: rtl/timer_pkg.sv
// Shared register map, bit positions and address helpers for the timer/compare unit.
package timer_pkg;

    localparam logic [11:0] ADDR_COUNT  = 12'h000;
    localparam logic [11:0] ADDR_CTRL   = 12'h004;
    localparam logic [11:0] ADDR_STATUS = 12'h008;
    localparam logic [11:0] ADDR_IRQ_EN = 12'h00C;
    localparam logic [11:0] CH_BASE     = 12'h100;
    localparam logic [11:0] CH_STRIDE   = 12'h010;

    localparam logic [3:0] CH_COMPARE = 4'h0;
    localparam logic [3:0] CH_PERIOD  = 4'h4;
    localparam logic [3:0] CH_CTRL    = 4'h8;

    localparam int RUN_BIT = 0;
    localparam int PRE_LSB = 8;
    localparam int OVF_BIT = 31;
    localparam int EN_BIT  = 0;
    localparam int PER_BIT = 1;

    typedef enum logic [1:0] {
        CH_REG_COMPARE,
        CH_REG_PERIOD,
        CH_REG_CTRL,
        CH_REG_NONE
    } ch_reg_e;

    // Offset within one channel's 16-byte window; offset 0xC is a hole.
    function automatic ch_reg_e ch_reg_decode(input logic [3:0] offset);
        case (offset)
            CH_COMPARE: return CH_REG_COMPARE;
            CH_PERIOD:  return CH_REG_PERIOD;
            CH_CTRL:    return CH_REG_CTRL;
            default:    return CH_REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/compare_channel.sv
// One compare channel: COMPARE/PERIOD/CHCTRL registers, match detect, reload or
// auto-disable, and the registered one-cycle match pulse.
module compare_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [WIDTH-1:0] count_next,
    input  logic             wr_compare,
    input  logic             wr_period,
    input  logic             wr_ctrl,
    input  logic [WIDTH-1:0] wr_data,
    output logic             hit,
    output logic             match_pulse,
    output logic [WIDTH-1:0] compare,
    output logic [WIDTH-1:0] period,
    output logic             enable,
    output logic             periodic
);

    // Compared against the value COUNT is about to take, so the match lands on
    // the same edge that makes COUNT equal to COMPARE.
    assign hit = tick && enable && (count_next == compare);

    always_ff @(posedge clk) begin
        if (reset) begin
            compare <= '1;
        end else if (wr_compare) begin
            compare <= wr_data;
        end else if (hit && periodic) begin
            compare <= compare + period;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            period <= '0;
        end else if (wr_period) begin
            period <= wr_data;
        end
    end

    // A software write to CHCTRL overrides the one-shot auto-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable   <= 1'b0;
            periodic <= 1'b0;
        end else if (wr_ctrl) begin
            enable   <= wr_data[EN_BIT];
            periodic <= wr_data[PER_BIT];
        end else if (hit && !periodic) begin
            enable   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            match_pulse <= 1'b0;
        end else begin
            match_pulse <= hit;
        end
    end

endmodule

// File: rtl/timer_compare_unit.sv
// Bus-mapped free-running timer with prescaler, overflow flag and NUM_CH compare
// channels feeding a sticky W1C status register and a masked interrupt line.
module timer_compare_unit
    import timer_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4,
    parameter int PRE_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CS_N,
    input  logic              WR_N,
    input  logic [11:0]       Addr,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic [NUM_CH-1:0] match_pulse,
    output logic              IRQ
);

    logic [11:0]      addr_w;
    logic             wr_en;
    logic             rd_en;
    logic             ch_region;
    logic [3:0]       ch_idx;
    ch_reg_e          ch_reg;
    logic             count_wr;
    logic             ctrl_wr;
    logic             status_wr;
    logic             irq_en_wr;
    logic             addr_unused;

    logic             run;
    logic [PRE_W-1:0] prescale;
    logic [PRE_W-1:0] pre_cnt;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_next;
    logic             tick;
    logic             ovf_set;

    logic [NUM_CH-1:0] status_match;
    logic              status_ovf;
    logic [NUM_CH-1:0] irq_en_match;
    logic              irq_en_ovf;
    logic [NUM_CH-1:0] w1c_match;
    logic              w1c_ovf;

    logic [NUM_CH-1:0] ch_hit;
    logic [WIDTH-1:0]  ch_compare  [NUM_CH];
    logic [WIDTH-1:0]  ch_period   [NUM_CH];
    logic              ch_enable   [NUM_CH];
    logic              ch_periodic [NUM_CH];

    logic [31:0]       rdata;

    assign addr_w      = {Addr[11:2], 2'b00};
    assign addr_unused = ^Addr[1:0];
    assign wr_en       = !CS_N && !WR_N;
    assign rd_en       = !CS_N && WR_N;
    assign ch_region   = (addr_w[11:8] == CH_BASE[11:8]);
    assign ch_idx      = addr_w[7:4];
    assign ch_reg      = ch_reg_decode(addr_w[3:0]);
    assign count_wr    = wr_en && (addr_w == ADDR_COUNT);
    assign ctrl_wr     = wr_en && (addr_w == ADDR_CTRL);
    assign status_wr   = wr_en && (addr_w == ADDR_STATUS);
    assign irq_en_wr   = wr_en && (addr_w == ADDR_IRQ_EN);

    // A COUNT write suppresses the tick, so no increment or match that cycle.
    assign tick       = run && (pre_cnt == prescale) && !count_wr;
    assign count_next = count + WIDTH'(1);
    assign ovf_set    = tick && (count == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            run      <= 1'b0;
            prescale <= '0;
        end else if (ctrl_wr) begin
            run      <= DataIn[RUN_BIT];
            prescale <= DataIn[PRE_LSB +: PRE_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || count_wr) begin
            pre_cnt <= '0;
        end else if (run) begin
            pre_cnt <= (pre_cnt == prescale) ? '0 : pre_cnt + PRE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (count_wr) begin
            count <= DataIn[WIDTH-1:0];
        end else if (tick) begin
            count <= count_next;
        end
    end

    // Hardware set is OR-ed in after the W1C clear so a same-edge event survives.
    assign w1c_match = status_wr ? DataIn[NUM_CH-1:0] : '0;
    assign w1c_ovf   = status_wr && DataIn[OVF_BIT];

    always_ff @(posedge clk) begin
        if (reset) begin
            status_match <= '0;
            status_ovf   <= 1'b0;
        end else begin
            status_match <= (status_match & ~w1c_match) | ch_hit;
            status_ovf   <= (status_ovf & ~w1c_ovf) | ovf_set;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_match <= '0;
            irq_en_ovf   <= 1'b0;
        end else if (irq_en_wr) begin
            irq_en_match <= DataIn[NUM_CH-1:0];
            irq_en_ovf   <= DataIn[OVF_BIT];
        end
    end

    assign IRQ = (|(status_match & irq_en_match)) || (status_ovf && irq_en_ovf);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = wr_en && ch_region && (ch_idx == 4'(i));

        compare_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .count_next (count_next),
            .wr_compare (sel && (ch_reg == CH_REG_COMPARE)),
            .wr_period  (sel && (ch_reg == CH_REG_PERIOD)),
            .wr_ctrl    (sel && (ch_reg == CH_REG_CTRL)),
            .wr_data    (DataIn[WIDTH-1:0]),
            .hit        (ch_hit[i]),
            .match_pulse(match_pulse[i]),
            .compare    (ch_compare[i]),
            .period     (ch_period[i]),
            .enable     (ch_enable[i]),
            .periodic   (ch_periodic[i])
        );
    end

    always_comb begin
        rdata = '0;
        case (addr_w)
            ADDR_COUNT: rdata = 32'(count);
            ADDR_CTRL: begin
                rdata[RUN_BIT]           = run;
                rdata[PRE_LSB +: PRE_W]  = prescale;
            end
            ADDR_STATUS: begin
                rdata[NUM_CH-1:0] = status_match;
                rdata[OVF_BIT]    = status_ovf;
            end
            ADDR_IRQ_EN: begin
                rdata[NUM_CH-1:0] = irq_en_match;
                rdata[OVF_BIT]    = irq_en_ovf;
            end
            default: begin
                if (ch_region) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (ch_idx == 4'(i)) begin
                            case (ch_reg)
                                CH_REG_COMPARE: rdata = 32'(ch_compare[i]);
                                CH_REG_PERIOD:  rdata = 32'(ch_period[i]);
                                CH_REG_CTRL: begin
                                    rdata[EN_BIT]  = ch_enable[i];
                                    rdata[PER_BIT] = ch_periodic[i];
                                end
                                default: rdata = '0;
                            endcase
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            DataOut <= '0;
        end else if (rd_en) begin
            DataOut <= rdata;
        end
    end

endmodule

// File: doc/timer_compare_unit.md
# timer_compare_unit

Memory-mapped, parametrised timer with one free-running up-counter and NUM_CH independent compare channels, each with one-shot or periodic (auto-advance) mode, sticky write-1-to-clear status and a masked interrupt output. It sits on the CPU's peripheral bus (CS_N/WR_N/Addr/DataIn strobe interface) and drives the processor interrupt line. It supersedes the single fixed compare register.

## Interface
- WIDTH, 32: counter, compare and period width (8..32).
- NUM_CH, 4: number of compare channels (1..16).
- PRE_W, 8: prescaler width.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- CS_N  in  1  chip select, active low.
- WR_N  in  1  write strobe, active low; read when high with CS_N low.
- Addr  in  12  byte address; Addr[1:0] ignored.
- DataIn  in  32  write data.
- DataOut  out  32  registered read data.
- match_pulse  out  NUM_CH  one-cycle pulse per channel match.
- IRQ  out  1  level interrupt, |(STATUS & IRQ_EN).

## Operation
- Register map:
  - 0x000 COUNT.
  - 0x004 CTRL: [0] run, [8+:PRE_W] prescale.
  - 0x008 STATUS: [i] match_i, [31] overflow; write-1-to-clear.
  - 0x00C IRQ_EN: same bit layout as STATUS.
  - 0x100+0x10·i COMPARE_i.
  - 0x104+0x10·i PERIOD_i.
  - 0x108+0x10·i CHCTRL_i: [0] enable, [1] periodic.
- Register widths: narrower registers zero-extend on read and truncate on write. Unmapped reads return 0; unmapped writes are ignored.
- Reset values:
  - COUNT, CTRL, STATUS, IRQ_EN, PERIOD, CHCTRL = 0.
  - COMPARE = all ones.
  - DataOut = 0, match_pulse = 0, IRQ = 0.
- Prescaler:
  - While run=1, pre_cnt increments each cycle.
  - tick asserts when pre_cnt == prescale; pre_cnt then returns to 0.
  - prescale=0 gives a tick every cycle. run=0 holds pre_cnt and COUNT.
- Counter: on tick, COUNT <= COUNT+1 mod 2^WIDTH. Wrap from all-ones to 0 sets STATUS[31].
- Match rule for channel i, evaluated on tick:
  - Condition: enable_i and count_next == COMPARE_i.
  - Effect: set STATUS[i] and pulse match_pulse[i] for one cycle.
  - Periodic: COMPARE_i <= COMPARE_i + PERIOD_i (mod 2^WIDTH); channel stays enabled.
  - One-shot: enable_i auto-clears.
- Software writes to COUNT:
  - COUNT loads DataIn and pre_cnt clears.
  - No tick or match is evaluated that cycle.
- Simultaneous events:
  - Hardware status set beats W1C clear of the same bit.
  - Software write to COMPARE_i or CHCTRL_i beats the hardware reload or auto-clear.
  - Write to COUNT beats the increment.
- Reset mid-operation returns everything to reset values on that edge, with no pulse.

## Timing
- Write: takes effect at the rising edge where CS_N=0 and WR_N=0.
- Read: DataOut is captured at the edge where CS_N=0 and WR_N=1, valid the following cycle (1-cycle latency). It holds its value otherwise.
- Match: the edge that makes COUNT == C also registers STATUS[i]=1 and match_pulse[i]=1. Those two and COUNT change together.
- IRQ: combinational from registered STATUS/IRQ_EN, so it is high in the same cycle as the status bit. It drops the cycle after a W1C write clears the last enabled bit.
- Counter rate: with prescale=P, COUNT advances once every P+1 cycles.

## Structure
- Package timer_pkg holds:
  - register offsets (ADDR_COUNT, ADDR_CTRL, ADDR_STATUS, ADDR_IRQ_EN, CH_BASE, CH_STRIDE, CH_COMPARE/PERIOD/CTRL offsets);
  - bit positions (RUN_BIT, PRE_LSB, OVF_BIT, EN_BIT, PER_BIT).
- Sub-module compare_channel is instantiated NUM_CH times via generate. It holds COMPARE/PERIOD/CHCTRL, the match compare, reload/auto-clear and the pulse.
- The top level holds the decode, prescaler, counter, STATUS/IRQ_EN and the read mux.

## Test plan
- Reset: after reset, read COMPARE_0 → 0xFFFFFFFF; COUNT, STATUS → 0; IRQ=0.
- One-shot: COMPARE_0=10, CHCTRL_0=1, IRQ_EN=1, CTRL=1 → match_pulse[0] once, with COUNT==10 and IRQ=1. CHCTRL_0 then reads 0. Writing STATUS=1 drops IRQ next cycle.
- Periodic with prescale: CTRL=0x0301, COMPARE_1=5, PERIOD_1=4, CHCTRL_1=3 → pulses at COUNT 5, 9, 13. Ticks are spaced 4 cycles apart.
- Overflow: COUNT=0xFFFFFFFE, CTRL=1, IRQ_EN=0x80000000 → STATUS[31] set on the 0→wrap edge; IRQ=1.
- Collision: W1C of STATUS[0] on the same edge as a channel-0 match → STATUS[0] remains 1. A COMPARE_0 write on the same edge as a periodic reload → the written value wins.
- Counter write: with COUNT=3 running, write COUNT=100 → reads 100, no increment that edge. Reset asserted mid-count zeroes COUNT and produces no pulse.
